// File: rtl/l2_cache_assoc.sv
// Set-associative write-back L2 cache with tree-PLRU replacement.
// Arrays are flip-flop based with combinational read; one outstanding request at a time.
module l2_cache_assoc #(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3,
    parameter int NUM_WAYS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [255:0] mem_wdata256,
    input  logic [31:0]  mem_byte_enable256,
    output logic [255:0] mem_rdata256,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count,
    output logic [31:0]  wb_count
);

    localparam int NUM_SETS = 1 << S_INDEX;
    localparam int WAY_W    = $clog2(NUM_WAYS);
    localparam int TAG_W    = 32 - S_OFFSET - S_INDEX;
    localparam int LINE_W   = 32 - S_OFFSET;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } state_t;

    state_t state;

    logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [255:0]        data_q  [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    logic [NUM_WAYS-2:0] plru_q  [NUM_SETS];

    logic              recheck_q;
    logic [WAY_W-1:0]  victim_q;
    logic [LINE_W-1:0] line_q;
    logic [TAG_W-1:0]  wb_tag_q;

    logic [TAG_W-1:0]    req_tag;
    logic [S_INDEX-1:0]  req_idx;
    logic [S_INDEX-1:0]  fill_idx;
    logic [NUM_WAYS-1:0] hit_vec;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic [WAY_W-1:0]    inv_way;
    logic                inv_any;
    logic [WAY_W-1:0]    victim;
    logic [NUM_WAYS-2:0] plru_next;
    logic [255:0]        merged_line;
    logic                unused_offset;

    // Walk the tree from the root; a 0 bit steers the victim into the lower half.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] bits);
        logic [WAY_W-1:0] w;
        logic             b;
        w = '0;
        for (int l = 0; l < WAY_W; l++) begin
            b = 1'b0;
            for (int p = 0; p < (1 << l); p++)
                if (w == WAY_W'(p)) b = bits[(1 << l) - 1 + p];
            w = (w << 1) | WAY_W'(b);
        end
        return w;
    endfunction

    // Point every node on the path to the accessed way towards the other half.
    function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] bits,
                                                        input logic [WAY_W-1:0]    way);
        logic [NUM_WAYS-2:0] nb;
        logic [WAY_W-1:0]    pre;
        nb = bits;
        for (int l = 0; l < WAY_W; l++) begin
            pre = way >> (WAY_W - l);
            for (int p = 0; p < (1 << l); p++)
                if (pre == WAY_W'(p)) nb[(1 << l) - 1 + p] = ~way[WAY_W-1-l];
        end
        return nb;
    endfunction

    assign req_tag       = mem_address[31:S_OFFSET+S_INDEX];
    assign req_idx       = mem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
    assign fill_idx      = line_q[S_INDEX-1:0];
    assign unused_offset = ^mem_address[S_OFFSET-1:0];

    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        inv_way = '0;
        for (int w = 0; w < NUM_WAYS; w++)
            hit_vec[w] = valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag);
        for (int w = 0; w < NUM_WAYS; w++)
            if (hit_vec[w]) hit_way = WAY_W'(w);
        for (int w = NUM_WAYS - 1; w >= 0; w--)
            if (!valid_q[req_idx][w]) inv_way = WAY_W'(w);
    end

    assign hit       = $onehot(hit_vec);
    assign inv_any   = ~&valid_q[req_idx];
    assign victim    = inv_any ? inv_way : plru_victim(plru_q[req_idx]);
    assign plru_next = plru_touch(plru_q[req_idx], hit_way);

    always_comb begin
        merged_line = data_q[req_idx][hit_way];
        for (int b = 0; b < 32; b++)
            if (mem_byte_enable256[b]) merged_line[8*b +: 8] = mem_wdata256[8*b +: 8];
    end

    assign mem_rdata256 = data_q[req_idx][hit_way];
    assign mem_resp     = (state == CHECK) && hit;
    assign pmem_read    = (state == FILL);
    assign pmem_write   = (state == WRITEBACK);
    assign pmem_wdata   = data_q[fill_idx][victim_q];
    assign pmem_address = (state == WRITEBACK) ? {wb_tag_q, fill_idx, {S_OFFSET{1'b0}}}
                                               : {line_q, {S_OFFSET{1'b0}}};

    // Line and tag storage carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (state == CHECK && hit && mem_write)
            data_q[req_idx][hit_way] <= merged_line;
        if (state == FILL && pmem_resp) begin
            data_q[fill_idx][victim_q] <= pmem_rdata;
            tag_q[fill_idx][victim_q]  <= line_q[LINE_W-1:S_INDEX];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            recheck_q  <= 1'b0;
            victim_q   <= '0;
            line_q     <= '0;
            wb_tag_q   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    recheck_q <= 1'b0;
                    if (mem_read || mem_write) state <= CHECK;
                end
                CHECK: begin
                    if (hit) begin
                        plru_q[req_idx] <= plru_next;
                        if (mem_write) dirty_q[req_idx][hit_way] <= 1'b1;
                        if (!recheck_q) hit_count <= hit_count + 32'd1;
                        recheck_q <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        miss_count <= miss_count + 32'd1;
                        victim_q   <= victim;
                        line_q     <= mem_address[31:S_OFFSET];
                        wb_tag_q   <= tag_q[req_idx][victim];
                        state      <= (valid_q[req_idx][victim] && dirty_q[req_idx][victim])
                                      ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        wb_count <= wb_count + 32'd1;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        valid_q[fill_idx][victim_q] <= 1'b1;
                        dirty_q[fill_idx][victim_q] <= 1'b0;
                        recheck_q                   <= 1'b1;
                        state                       <= CHECK;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_cache_assoc.sv
// Directed bench for l2_cache_assoc: miss/fill, hit latency, byte-merge writes,
// dirty eviction, reset during fill and simultaneous read/write strobes.
module tb_l2_cache_assoc;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read, mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata256;
    logic [31:0]  mem_byte_enable256;
    logic [255:0] mem_rdata256;
    logic         mem_resp;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         rsp_resp, spur_resp;
    logic [31:0]  hit_count, miss_count, wb_count;

    int vectors = 0;
    int miscompares = 0;
    int viol = 0;
    bit mem_en = 1'b1;

    logic [31:0]  ev_addr[$];
    bit           ev_wr[$];
    logic [255:0] wb_data;

    l2_cache_assoc #(.S_OFFSET(5), .S_INDEX(3), .NUM_WAYS(4)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata256(mem_wdata256), .mem_byte_enable256(mem_byte_enable256),
        .mem_rdata256(mem_rdata256), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(rsp_resp | spur_resp),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] line_pat(input logic [31:0] a);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = a ^ (32'h1111_1111 * 32'(i + 1));
        return r;
    endfunction

    // Backing memory: answers each strobe three cycles after first seeing it.
    initial begin
        rsp_resp   = 1'b0;
        pmem_rdata = '0;
        wb_data    = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_en && (pmem_read || pmem_write)) begin
                ev_addr.push_back(pmem_address);
                ev_wr.push_back(pmem_write);
                if (pmem_write) wb_data = pmem_wdata;
                repeat (2) @(posedge clk);
                #1;
                rsp_resp   = 1'b1;
                pmem_rdata = line_pat(pmem_address);
                @(posedge clk); #1;
                rsp_resp = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if ((mem_resp && (pmem_read || pmem_write)) || (pmem_read && pmem_write) ||
                (mem_resp && dut.state != 2'd1))
                viol = viol + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [255:0] wd, input logic [31:0] be,
                          output logic [255:0] rdata, output int lat);
        int n;
        mem_address = a; mem_wdata256 = wd; mem_byte_enable256 = be;
        mem_read = rd; mem_write = wr;
        rdata = '0;
        for (n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (mem_resp) break;
        end
        lat = n;
        if (mem_resp) begin
            rdata = mem_rdata256;
        end else begin
            vectors++; miscompares++;
            $display("FAIL req_timeout addr=%h: no mem_resp within 60 cycles", a);
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        vectors++;
        if (mem_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_strobes got resp=%b rd=%b wr=%b want 0 0 0", mem_resp, pmem_read, pmem_write);
        end
        vectors++;
        if ({hit_count, miss_count, wb_count} !== 96'd0) begin
            miscompares++;
            $display("FAIL reset_counters got %0d %0d %0d want 0 0 0", hit_count, miss_count, wb_count);
        end
        vectors++;
        if (dut.state !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state got %0d want 0", dut.state);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_miss;
        logic [255:0] rd; int lat; int n0;
        n0 = ev_addr.size();
        do_req(1'b1, 1'b0, 32'h40, '0, '0, rd, lat);
        vectors++;
        if (rd !== line_pat(32'h40)) begin
            miscompares++; $display("FAIL miss_rdata got %h want %h", rd, line_pat(32'h40));
        end
        vectors++;
        if (ev_addr.size() != n0 + 1 || ev_addr[n0] !== 32'h40 || ev_wr[n0] !== 1'b0) begin
            miscompares++; $display("FAIL miss_pmem got %0d events want one read of 00000040", ev_addr.size() - n0);
        end
        vectors++;
        if (miss_count !== 32'd1) begin
            miscompares++; $display("FAIL miss_count got %0d want 1", miss_count);
        end
        vectors++;
        if (hit_count !== 32'd0) begin
            miscompares++; $display("FAIL miss_hitcnt got %0d want 0", hit_count);
        end
    endtask

    task automatic test_read_hit;
        logic [255:0] rd; int lat; int n0;
        n0 = ev_addr.size();
        do_req(1'b1, 1'b0, 32'h40, '0, '0, rd, lat);
        vectors++;
        if (lat !== 1) begin
            miscompares++; $display("FAIL hit_latency got %0d want 1", lat);
        end
        vectors++;
        if (rd !== line_pat(32'h40)) begin
            miscompares++; $display("FAIL hit_rdata got %h want %h", rd, line_pat(32'h40));
        end
        vectors++;
        if (ev_addr.size() != n0) begin
            miscompares++; $display("FAIL hit_pmem got %0d events want 0", ev_addr.size() - n0);
        end
        vectors++;
        if (hit_count !== 32'd1) begin
            miscompares++; $display("FAIL hit_count got %0d want 1", hit_count);
        end
    endtask

    task automatic test_write_hit;
        logic [255:0] rd, wd, ln, exp; int lat;
        ln  = line_pat(32'h40);
        wd  = {{7{32'h0123_4567}}, 32'hAABB_CCDD};
        exp = {ln[255:32], 32'hAABB_CCDD};
        do_req(1'b0, 1'b1, 32'h40, wd, 32'h0000_000F, rd, lat);
        vectors++;
        if (lat !== 1) begin
            miscompares++; $display("FAIL wr_latency got %0d want 1", lat);
        end
        vectors++;
        if (dut.dirty_q[2][0] !== 1'b1) begin
            miscompares++; $display("FAIL wr_dirty got %b want 1", dut.dirty_q[2][0]);
        end
        do_req(1'b1, 1'b0, 32'h40, '0, '0, rd, lat);
        vectors++;
        if (rd !== exp) begin
            miscompares++; $display("FAIL wr_merge got %h want %h", rd, exp);
        end
        vectors++;
        if (hit_count !== 32'd3) begin
            miscompares++; $display("FAIL wr_hitcnt got %0d want 3", hit_count);
        end
    endtask

    task automatic test_evict;
        logic [31:0]  addrs [3];
        logic [255:0] rd, ln, exp; int lat; int n0;
        addrs[0] = 32'h140; addrs[1] = 32'h240; addrs[2] = 32'h340;
        ln  = line_pat(32'h40);
        exp = {ln[255:32], 32'hAABB_CCDD};
        for (int i = 0; i < 3; i++) begin
            do_req(1'b1, 1'b0, addrs[i], '0, '0, rd, lat);
            vectors++;
            if (rd !== line_pat(addrs[i])) begin
                miscompares++; $display("FAIL evict_fill%0d got %h want %h", i, rd, line_pat(addrs[i]));
            end
        end
        n0 = ev_addr.size();
        do_req(1'b1, 1'b0, 32'h440, '0, '0, rd, lat);
        vectors++;
        if (ev_addr.size() != n0 + 2 || ev_addr[n0] !== 32'h40 || ev_wr[n0] !== 1'b1 ||
            ev_addr[n0+1] !== 32'h440 || ev_wr[n0+1] !== 1'b0) begin
            miscompares++;
            $display("FAIL evict_order got %0d events want write 00000040 then read 00000440", ev_addr.size() - n0);
        end
        vectors++;
        if (wb_data !== exp) begin
            miscompares++; $display("FAIL evict_wbdata got %h want %h", wb_data, exp);
        end
        vectors++;
        if (wb_count !== 32'd1) begin
            miscompares++; $display("FAIL wb_count got %0d want 1", wb_count);
        end
        vectors++;
        if (miss_count !== 32'd5 || hit_count !== 32'd3) begin
            miscompares++; $display("FAIL evict_counts got miss=%0d hit=%0d want 5 3", miss_count, hit_count);
        end
        vectors++;
        if (rd !== line_pat(32'h440)) begin
            miscompares++; $display("FAIL evict_rdata got %h want %h", rd, line_pat(32'h440));
        end
        vectors++;
        if (dut.tag_q[2][0] !== 24'd4 || dut.dirty_q[2][0] !== 1'b0) begin
            miscompares++; $display("FAIL evict_way0 got tag=%h dirty=%b want 4 0", dut.tag_q[2][0], dut.dirty_q[2][0]);
        end
    endtask

    task automatic test_reset_fill;
        logic [255:0] rd; int lat; int n0; bit seen;
        mem_en = 1'b0;
        mem_address = 32'h80; mem_read = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            seen = pmem_read;
        end
        vectors++;
        if (!seen) begin
            miscompares++; $display("FAIL rstfill_enter got pmem_read=0 want 1 within 20 cycles");
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (pmem_read !== 1'b0 || dut.state !== 2'd0) begin
            miscompares++; $display("FAIL rstfill_abort got rd=%b state=%0d want 0 0", pmem_read, dut.state);
        end
        vectors++;
        if (dut.valid_q[4] !== 4'b0000 || miss_count !== 32'd0) begin
            miscompares++; $display("FAIL rstfill_clear got valid=%b miss=%0d want 0000 0", dut.valid_q[4], miss_count);
        end
        mem_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; mem_en = 1'b1;
        @(posedge clk); #1;
        n0 = ev_addr.size();
        do_req(1'b1, 1'b0, 32'h80, '0, '0, rd, lat);
        vectors++;
        if (miss_count !== 32'd1 || hit_count !== 32'd0) begin
            miscompares++; $display("FAIL rstfill_miss got miss=%0d hit=%0d want 1 0", miss_count, hit_count);
        end
        vectors++;
        if (ev_addr.size() != n0 + 1 || ev_addr[n0] !== 32'h80 || rd !== line_pat(32'h80)) begin
            miscompares++; $display("FAIL rstfill_refill got %0d events rd=%h want one read of 00000080", ev_addr.size() - n0, rd);
        end
    endtask

    task automatic test_both_strobes;
        logic [255:0] rd, wd; int lat;
        wd = {8{32'hDEAD_BEEF}};
        do_req(1'b1, 1'b1, 32'h80, wd, 32'hFFFF_FFFF, rd, lat);
        vectors++;
        if (lat !== 1 || dut.dirty_q[4][0] !== 1'b1) begin
            miscompares++; $display("FAIL both_write got lat=%0d dirty=%b want 1 1", lat, dut.dirty_q[4][0]);
        end
        do_req(1'b1, 1'b0, 32'h80, '0, '0, rd, lat);
        vectors++;
        if (rd !== wd) begin
            miscompares++; $display("FAIL both_rdata got %h want %h", rd, wd);
        end
        vectors++;
        if (hit_count !== 32'd2) begin
            miscompares++; $display("FAIL both_hitcnt got %0d want 2", hit_count);
        end
        mem_en = 1'b0;
        spur_resp = 1'b1;
        @(posedge clk); #1;
        spur_resp = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (dut.state !== 2'd0 || pmem_read !== 1'b0 || pmem_write !== 1'b0 || mem_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL spurious_resp got state=%0d rd=%b wr=%b resp=%b want 0 0 0 0", dut.state, pmem_read, pmem_write, mem_resp);
        end
        vectors++;
        if (wb_count !== 32'd0 || miss_count !== 32'd1) begin
            miscompares++; $display("FAIL spurious_counts got wb=%0d miss=%0d want 0 1", wb_count, miss_count);
        end
        mem_en = 1'b1;
    endtask

    task automatic test_exclusive;
        vectors++;
        if (viol !== 0) begin
            miscompares++; $display("FAIL strobe_exclusive got %0d violating cycles want 0", viol);
        end
    endtask

    initial begin
        rst = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0;
        mem_address = '0; mem_wdata256 = '0; mem_byte_enable256 = '0;
        spur_resp = 1'b0;
        repeat (2) @(posedge clk);
        test_reset;
        test_read_miss;
        test_read_hit;
        test_write_hit;
        test_evict;
        test_reset_fill;
        test_both_strobes;
        test_exclusive;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/l2_cache_assoc.md
L2_CACHE_ASSOC -- requirements
Module: l2_cache_assoc

Interface
REQ-001 SHALL have parameter S_OFFSET, default 5, meaning log2 of line bytes; the line is 256 bits and S_OFFSET is fixed at 5.
REQ-002 SHALL have parameter S_INDEX, default 3, meaning log2 of set count (legal 1..6).
REQ-003 SHALL have parameter NUM_WAYS, default 4, meaning associativity; power of two, legal values 2..8.
REQ-004 SHALL have port clk  in  1  single clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port mem_read / mem_write  in  1 each  upstream request strobes, held until mem_resp.
REQ-007 SHALL have port mem_address  in  32  byte address; tag = [31:S_OFFSET+S_INDEX], index = [S_OFFSET+S_INDEX-1:S_OFFSET].
REQ-008 SHALL have port mem_wdata256 in 256 and mem_byte_enable256 in 32: write data and byte enables.
REQ-009 SHALL have port mem_rdata256 out 256 and mem_resp out 1: read line and one-cycle completion pulse.
REQ-010 SHALL have port pmem_read / pmem_write  out  1 each  downstream strobes, held until pmem_resp.
REQ-011 SHALL have port pmem_address out 32, pmem_wdata out 256, pmem_rdata in 256 and pmem_resp in 1.
REQ-012 SHALL have port hit_count / miss_count / wb_count  out  32 each  wrapping event counters.

Function
REQ-013 SHALL store per set and way a tag, a valid bit, a dirty bit and a 256-bit line in flip-flop arrays with combinational read; each set SHALL also hold NUM_WAYS-1 tree-PLRU bits.
REQ-014 SHALL implement the FSM states IDLE, CHECK, WRITEBACK and FILL, entering IDLE on reset.
REQ-015 In IDLE with mem_read or mem_write high, SHALL go to CHECK on the next cycle; if both are high, the request SHALL be treated as a write.
REQ-016 In CHECK, a hit (valid and tag equal in exactly one way) SHALL pulse mem_resp for that cycle, drive mem_rdata256 with the hit line, update PLRU away from the hit way, and return to IDLE; hit latency is therefore 1 cycle after the request is sampled.
REQ-017 On a write hit, SHALL merge mem_wdata256 bytes where mem_byte_enable256 is 1 and set dirty=1 in the same CHECK edge.
REQ-018 On a miss in CHECK, SHALL choose the victim as the lowest-numbered invalid way, or the PLRU way if all ways are valid; PLRU bit 0 selects the lower half of the subtree.
REQ-019 On a miss, SHALL go to WRITEBACK if the victim is valid and dirty, and to FILL otherwise.
REQ-020 In WRITEBACK, SHALL assert pmem_write with pmem_address = {victim tag, index, 5'b0} and pmem_wdata = victim line, and on pmem_resp go to FILL.
REQ-021 In FILL, SHALL assert pmem_read with pmem_address = {mem_address[31:5], 5'b0}; on pmem_resp it SHALL write pmem_rdata into the victim, set valid=1, dirty=0 and tag, then return to CHECK, which then hits.
REQ-022 The victim way and line address SHALL be latched at CHECK miss and stay stable through WRITEBACK/FILL regardless of PLRU.
REQ-023 mem_resp, pmem_read and pmem_write SHALL never be asserted simultaneously, and mem_resp SHALL be high only in CHECK.
REQ-024 hit_count SHALL increment on each CHECK hit that is not the post-FILL recheck; miss_count SHALL increment on each CHECK miss; wb_count SHALL increment on each WRITEBACK pmem_resp; all three wrap from 2^32-1 to 0.
REQ-025 pmem_resp received outside WRITEBACK/FILL SHALL be ignored.

Reset
REQ-026 While rst=0, asynchronously: state=IDLE; all valid, dirty and PLRU bits=0; counters=0; mem_resp, pmem_read and pmem_write=0; data and tag arrays are not required to be cleared.
REQ-027 Reset asserted mid-WRITEBACK/FILL SHALL deassert pmem strobes immediately and abandon the transaction with no array update.

Verification
REQ-028 After reset, read 0x0000_0040 with pmem returning line L after 3 cycles -> pmem_read for 0x40, then CHECK hit, mem_rdata256=L, miss_count=1, hit_count=0.
REQ-029 Repeat the same read -> mem_resp exactly 1 cycle after the request is sampled, no pmem activity, hit_count=1.
REQ-030 Write 0x40 with byte_enable=0x0000_000F, data 0xAABBCCDD in the low word -> read back shows the low 4 bytes changed and the rest equal to L, with dirty set.
REQ-031 Fill 5 distinct tags into index 2 (NUM_WAYS=4) with way 0 dirty and PLRU pointing at way 0 -> WRITEBACK to the old way-0 address precedes FILL, wb_count=1.
REQ-032 Assert rst low during FILL -> pmem_read drops in the same cycle, state=IDLE, and a read of the previous address misses.
REQ-033 Drive mem_read and mem_write together -> write semantics with dirty=1, and a spurious pmem_resp in IDLE causes no state change.
